// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card device model and SPI loopback target.
// It decodes 6-byte SD command frames from an SPI mode-0 master. It answers
// CMD0/8/55/ACMD41/58/17 with R1/R3/R7 responses. For CMD17 it returns a
// single 512-byte data block filled with a synthetic incrementing pattern.
//
// Ports:
//   clock      system clock, at least 4x spi_sclk
//   reset      asynchronous, active-high reset
//   spi_cs     chip select, active-low, asynchronous to clock
//   spi_sclk   SPI clock (mode 0), asynchronous to clock
//   spi_mosi   master-out data, MSB first
//   spi_miso   slave-out data, idles at 1
//   cmd_valid  one-clock pulse when a command frame has been decoded
//   cmd_index  index of the last decoded command
//   cmd_arg    argument of the last decoded command
//   busy       a response or data block is pending or in progress
module sd_spi_responder #(
  parameter int unsigned ACMD41_BUSY = 2,
  parameter logic [31:0] OCR         = 32'hC0FF8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        busy
);

  typedef enum logic [2:0] {
    StWait,
    StFrame,
    StResp,
    StToken,
    StData,
    StCrc
  } state_e;

  state_e      state_q;
  logic [1:0]  cs_sync_q;
  logic [1:0]  sclk_sync_q;
  logic [1:0]  mosi_sync_q;
  logic        sclk_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_q;
  logic [7:0]  tx_q;
  logic [2:0]  frame_cnt_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [39:0] resp_q;
  logic [2:0]  resp_left_q;
  logic        data_pend_q;
  logic [9:0]  data_cnt_q;
  logic        idle_q;
  logic        app_q;
  logic [15:0] acmd_cnt_q;

  logic        sclk_rise;
  logic        sclk_fall;
  logic [7:0]  rx_byte;
  logic [7:0]  r1_idle;
  logic [7:0]  r1_illegal;

  // Response decode for the frame currently held in idx_q/arg_q
  logic [39:0] resp_d;
  logic [2:0]  resp_len_d;
  logic        data_d;
  logic        idle_d;
  logic        app_d;
  logic [15:0] acmd_cnt_d;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_prev_q;
  assign rx_byte    = {rx_q, mosi_sync_q[1]};
  assign r1_idle    = {7'b0, idle_q};
  assign r1_illegal = {5'b0, 1'b1, 1'b0, idle_q};
  assign busy       = (state_q == StResp) || (state_q == StToken) ||
                      (state_q == StData) || (state_q == StCrc);

  always_comb begin
    resp_d     = {r1_illegal, 32'hFFFF_FFFF};
    resp_len_d = 3'd1;
    data_d     = 1'b0;
    idle_d     = idle_q;
    app_d      = (idx_q == 6'd55);
    acmd_cnt_d = acmd_cnt_q;
    case (idx_q)
      6'd0: begin
        resp_d     = {8'h01, 32'hFFFF_FFFF};
        idle_d     = 1'b1;
        acmd_cnt_d = '0;
      end
      6'd8: begin
        resp_d     = {r1_idle, 24'h000001, arg_q[7:0]};
        resp_len_d = 3'd5;
      end
      6'd17: begin
        resp_d = {r1_idle, 32'hFFFF_FFFF};
        data_d = ~idle_q;
      end
      6'd41: begin
        if (app_q) begin
          if (acmd_cnt_q < 16'(ACMD41_BUSY)) begin
            resp_d     = {8'h01, 32'hFFFF_FFFF};
            acmd_cnt_d = acmd_cnt_q + 16'd1;
          end else begin
            resp_d = {8'h00, 32'hFFFF_FFFF};
            idle_d = 1'b0;
          end
        end
      end
      6'd55: begin
        resp_d = {r1_idle, 32'hFFFF_FFFF};
      end
      6'd58: begin
        resp_d     = {r1_idle, OCR};
        resp_len_d = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StWait;
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b11;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= 8'hFF;
      spi_miso    <= 1'b1;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      resp_q      <= '1;
      resp_left_q <= '0;
      data_pend_q <= 1'b0;
      data_cnt_q  <= '0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      acmd_cnt_q  <= '0;
      cmd_valid   <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cmd_valid   <= 1'b0;

      if (cs_sync_q[1]) begin
        // Deselected: drop any partial frame or transfer, keep card state
        state_q   <= StWait;
        bit_cnt_q <= '0;
        tx_q      <= 8'hFF;
        spi_miso  <= 1'b1;
      end else begin
        if (sclk_fall) begin
          spi_miso <= tx_q[7];
          tx_q     <= {tx_q[6:0], 1'b1};
        end

        if (sclk_rise) begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;

          if (bit_cnt_q == 3'd7) begin
            // Byte boundary: tx_q gets the byte for the next slot
            tx_q <= 8'hFF;
            unique case (state_q)
              StWait: begin
                if (rx_byte[7:6] == 2'b01) begin
                  state_q     <= StFrame;
                  idx_q       <= rx_byte[5:0];
                  frame_cnt_q <= 3'd1;
                end
              end
              StFrame: begin
                if (frame_cnt_q == 3'd5) begin
                  // CRC byte: never checked; frame is complete
                  state_q     <= StResp;
                  cmd_valid   <= 1'b1;
                  cmd_index   <= idx_q;
                  cmd_arg     <= arg_q;
                  resp_q      <= resp_d;
                  resp_left_q <= resp_len_d;
                  data_pend_q <= data_d;
                  idle_q      <= idle_d;
                  app_q       <= app_d;
                  acmd_cnt_q  <= acmd_cnt_d;
                end else begin
                  arg_q       <= {arg_q[23:0], rx_byte};
                  frame_cnt_q <= frame_cnt_q + 3'd1;
                end
              end
              StResp: begin
                if (resp_left_q != 3'd0) begin
                  tx_q        <= resp_q[39:32];
                  resp_q      <= {resp_q[31:0], 8'hFF};
                  resp_left_q <= resp_left_q - 3'd1;
                end else if (data_pend_q) begin
                  state_q <= StToken;  // this slot is the 0xFF gap byte
                end else begin
                  state_q <= StWait;
                end
              end
              StToken: begin
                tx_q       <= 8'hFE;
                state_q    <= StData;
                data_cnt_q <= '0;
              end
              StData: begin
                tx_q <= cmd_arg[7:0] + data_cnt_q[7:0];
                if (data_cnt_q == 10'd511) begin
                  state_q    <= StCrc;
                  data_cnt_q <= '0;
                end else begin
                  data_cnt_q <= data_cnt_q + 10'd1;
                end
              end
              StCrc: begin
                // Two 0xFF CRC slots, then release once the second has gone out
                if (data_cnt_q == 10'd2) begin
                  state_q <= StWait;
                end else begin
                  data_cnt_q <= data_cnt_q + 10'd1;
                end
              end
              default: state_q <= StWait;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed testbench for sd_spi_responder: drives an SPI mode-0 master with
// a half period of four system clocks and checks responses byte by byte.
module tb_sd_spi_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;

  int checks     = 0;
  int errors     = 0;
  int exp_valid  = 0;
  int valid_seen = 0;

  always #5 clock = ~clock;

  sd_spi_responder #(
    .ACMD41_BUSY(2),
    .OCR        (32'hC0FF8000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .cmd_arg  (cmd_arg),
    .busy     (busy)
  );

  always @(posedge clock) begin
    if (cmd_valid === 1'b1) valid_seen <= valid_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One byte, MSB first; MISO is sampled just before each rising edge
  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #40;
      r[i]     = spi_miso;
      spi_sclk = 1'b1;
      #40;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] r;
    xfer({2'b01, idx}, r);
    for (int i = 3; i >= 0; i--) xfer(arg[i*8 +: 8], r);
    xfer(crc, r);
    exp_valid++;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    xfer(8'hFF, r);
    check(tag, {24'b0, r}, {24'b0, exp});
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] e;
    int         busy_bad;

    reset    = 1'b1;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b1;
    #32;
    reset = 1'b0;
    #10;
    check("rst_miso", {31'b0, spi_miso}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_cmd_index", {26'b0, cmd_index}, 32'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);

    spi_cs = 1'b0;
    #60;
    for (int i = 0; i < 10; i++) expect_byte("idle_ff", 8'hFF);
    check("idle_no_valid", valid_seen, 32'd0);

    // Illegal command while idle
    send_cmd(6'd1, 32'h0, 8'hFF);
    expect_byte("cmd1_ncr", 8'hFF);
    expect_byte("cmd1_r1_idle", 8'h05);
    check("cmd1_index", {26'b0, cmd_index}, 32'd1);

    send_cmd(6'd0, 32'h0, 8'h95);
    expect_byte("cmd0_ncr", 8'hFF);
    expect_byte("cmd0_r1", 8'h01);
    check("cmd0_index", {26'b0, cmd_index}, 32'd0);

    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    expect_byte("cmd8_ncr", 8'hFF);
    expect_byte("cmd8_r1", 8'h01);
    expect_byte("cmd8_b1", 8'h00);
    expect_byte("cmd8_b2", 8'h00);
    expect_byte("cmd8_b3", 8'h01);
    expect_byte("cmd8_echo", 8'hAA);
    check("cmd8_index", {26'b0, cmd_index}, 32'd8);
    check("cmd8_arg", cmd_arg, 32'h0000_01AA);

    send_cmd(6'd41, 32'h4000_0000, 8'hFF);
    expect_byte("bare41_ncr", 8'hFF);
    expect_byte("bare41_r1_idle", 8'h05);

    send_cmd(6'd55, 32'h0, 8'hFF);
    expect_byte("cmd55a_ncr", 8'hFF);
    expect_byte("cmd55a_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'hFF);
    expect_byte("acmd41a_ncr", 8'hFF);
    expect_byte("acmd41a_r1", 8'h01);
    send_cmd(6'd55, 32'h0, 8'hFF);
    expect_byte("cmd55b_ncr", 8'hFF);
    expect_byte("cmd55b_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'hFF);
    expect_byte("acmd41b_ncr", 8'hFF);
    expect_byte("acmd41b_r1", 8'h01);
    send_cmd(6'd55, 32'h0, 8'hFF);
    expect_byte("cmd55c_ncr", 8'hFF);
    expect_byte("cmd55c_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'hFF);
    expect_byte("acmd41c_ncr", 8'hFF);
    expect_byte("acmd41c_r1", 8'h00);

    send_cmd(6'd58, 32'h0, 8'hFF);
    expect_byte("cmd58_ncr", 8'hFF);
    expect_byte("cmd58_r1", 8'h00);
    expect_byte("cmd58_ocr3", 8'hC0);
    expect_byte("cmd58_ocr2", 8'hFF);
    expect_byte("cmd58_ocr1", 8'h80);
    expect_byte("cmd58_ocr0", 8'h00);

    send_cmd(6'd1, 32'h0, 8'hFF);
    expect_byte("cmd1b_ncr", 8'hFF);
    expect_byte("cmd1b_r1", 8'h04);
    send_cmd(6'd41, 32'h0, 8'hFF);
    expect_byte("bare41b_ncr", 8'hFF);
    expect_byte("bare41b_r1", 8'h04);

    // Full single-block read
    send_cmd(6'd17, 32'h0000_0010, 8'hFF);
    expect_byte("cmd17_ncr", 8'hFF);
    expect_byte("cmd17_r1", 8'h00);
    check("cmd17_busy", {31'b0, busy}, 32'd1);
    expect_byte("cmd17_gap", 8'hFF);
    expect_byte("cmd17_token", 8'hFE);
    busy_bad = 0;
    for (int i = 0; i < 512; i++) begin
      e = 8'h10 + i[7:0];
      xfer(8'hFF, r);
      check("cmd17_data", {24'b0, r}, {24'b0, e});
      if (busy !== 1'b1) busy_bad++;
    end
    check("cmd17_busy_during_data", busy_bad, 32'd0);
    expect_byte("cmd17_crc1", 8'hFF);
    expect_byte("cmd17_crc2", 8'hFF);
    #100;
    check("cmd17_busy_after", {31'b0, busy}, 32'd0);
    check("cmd17_index", {26'b0, cmd_index}, 32'd17);
    check("cmd17_arg", cmd_arg, 32'h0000_0010);

    // Abort a read mid-block with CS
    send_cmd(6'd17, 32'h0000_00A0, 8'hFF);
    expect_byte("abort_ncr", 8'hFF);
    expect_byte("abort_r1", 8'h00);
    expect_byte("abort_gap", 8'hFF);
    expect_byte("abort_token", 8'hFE);
    for (int i = 0; i < 100; i++) xfer(8'hFF, r);
    expect_byte("abort_byte100", 8'h04);
    spi_cs = 1'b1;
    #200;
    check("abort_miso", {31'b0, spi_miso}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    spi_cs = 1'b0;
    #100;
    expect_byte("abort_ff0", 8'hFF);
    expect_byte("abort_ff1", 8'hFF);

    send_cmd(6'd17, 32'h0000_00A0, 8'hFF);
    expect_byte("restart_ncr", 8'hFF);
    expect_byte("restart_r1", 8'h00);
    expect_byte("restart_gap", 8'hFF);
    expect_byte("restart_token", 8'hFE);
    expect_byte("restart_byte0", 8'hA0);
    expect_byte("restart_byte1", 8'hA1);
    spi_cs = 1'b1;
    #200;
    check("restart_busy", {31'b0, busy}, 32'd0);
    check("valid_pulses", valid_seen, exp_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
